// File: rtl/l1_l2_bus_arbiter_if.sv
// L1/L2 arbiter handshake bundle: I-cache, D-cache, L2 command, and snoop channels.
// master = the arbiter itself, slave = the caches/L2 environment around it.
interface l1_l2_bus_arbiter_if #(
    parameter int ADDRESS_BITS = 32
);
    logic                    i_req;
    logic [ADDRESS_BITS-1:0] i_addr;
    logic                    i_gnt;
    logic                    i_done;

    logic                    d_req;
    logic [1:0]              d_op;
    logic [ADDRESS_BITS-1:0] d_addr;
    logic                    d_gnt;
    logic                    d_done;

    logic                    l2_valid;
    logic [1:0]              l2_op;
    logic [ADDRESS_BITS-1:0] l2_addr;
    logic                    l2_ready;
    logic                    l2_resp;

    logic                    snp_valid;
    logic                    snp_op;
    logic [ADDRESS_BITS-1:0] snp_addr;
    logic                    snp_ready;

    logic                    dsnp_valid;
    logic                    dsnp_op;
    logic [ADDRESS_BITS-1:0] dsnp_addr;
    logic                    dsnp_done;

    logic                    proto_err;

    modport master (
        input  i_req, i_addr, d_req, d_op, d_addr,
        input  l2_ready, l2_resp, snp_valid, snp_op, snp_addr, dsnp_done,
        output i_gnt, i_done, d_gnt, d_done,
        output l2_valid, l2_op, l2_addr, snp_ready,
        output dsnp_valid, dsnp_op, dsnp_addr, proto_err
    );

    modport slave (
        output i_req, i_addr, d_req, d_op, d_addr,
        output l2_ready, l2_resp, snp_valid, snp_op, snp_addr, dsnp_done,
        input  i_gnt, i_done, d_gnt, d_done,
        input  l2_valid, l2_op, l2_addr, snp_ready,
        input  dsnp_valid, dsnp_op, dsnp_addr, proto_err
    );
endinterface

// File: rtl/l1_l2_bus_arbiter.sv
// Serialises I/D-cache misses and L2 snoops onto the single L2 port, one transaction at a time.
// Latency: grant + l2_valid one cycle after the request is sampled in IDLE; done one cycle after l2_resp.
// Backpressure: l2_ready stalls ISSUE; requests and snoops are held by their sources until grant/snp_ready.
module l1_l2_bus_arbiter #(
    parameter int ADDRESS_BITS = 32,
    parameter int OFFSET_BITS  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    l1_l2_bus_arbiter_if.master    bus
);
    localparam int   LINE_BITS = ADDRESS_BITS - OFFSET_BITS;
    localparam logic OWN_I     = 1'b0;
    localparam logic OWN_D     = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, SNOOP} state_t;

    typedef struct packed {
        logic                 owner;
        logic [1:0]           op;
        logic [LINE_BITS-1:0] line;
    } txn_t;

    state_t               state_q, state_d;
    txn_t                 txn_q, txn_d;
    logic                 last_grant_q;
    logic                 snp_op_q;
    logic [LINE_BITS-1:0] snp_line_q;
    logic                 i_gnt_q, d_gnt_q, i_done_q, d_done_q, snp_ready_q, proto_err_q;
    logic                 snp_take, d_wb, pick_d, req_any, start_txn, resp_ok;
    logic                 unused_offsets;

    assign unused_offsets = ^{bus.i_addr[OFFSET_BITS-1:0], bus.d_addr[OFFSET_BITS-1:0],
                              bus.snp_addr[OFFSET_BITS-1:0]};

    // A snoop still held during its own snp_ready cycle has already been serviced.
    always_comb begin
        snp_take   = bus.snp_valid && !snp_ready_q;
        d_wb       = bus.d_req && (bus.d_op == 2'd2);
        req_any    = bus.i_req || bus.d_req;
        pick_d     = d_wb || (bus.d_req && (!bus.i_req || last_grant_q == OWN_I));
        txn_d.owner = pick_d ? OWN_D : OWN_I;
        txn_d.op    = (pick_d && bus.d_op != 2'd3) ? bus.d_op : 2'd0;
        txn_d.line  = pick_d ? bus.d_addr[ADDRESS_BITS-1:OFFSET_BITS]
                             : bus.i_addr[ADDRESS_BITS-1:OFFSET_BITS];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (snp_take)     state_d = SNOOP;
                else if (req_any) state_d = ISSUE;
            end
            ISSUE:     if (bus.l2_ready)  state_d = WAIT_RESP;
            WAIT_RESP: if (bus.l2_resp)   state_d = IDLE;
            SNOOP:     if (bus.dsnp_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign start_txn = (state_q == IDLE) && (state_d == ISSUE);
    assign resp_ok   = (state_q == WAIT_RESP) && bus.l2_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_q        <= '0;
            last_grant_q <= OWN_D;
            snp_op_q     <= 1'b0;
            snp_line_q   <= '0;
            i_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            snp_ready_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            i_gnt_q     <= start_txn && !pick_d;
            d_gnt_q     <= start_txn && pick_d;
            i_done_q    <= resp_ok && (txn_q.owner == OWN_I);
            d_done_q    <= resp_ok && (txn_q.owner == OWN_D);
            snp_ready_q <= (state_q == SNOOP) && bus.dsnp_done;
            if (start_txn) txn_q <= txn_d;
            if (resp_ok)   last_grant_q <= txn_q.owner;
            if (state_q == IDLE && snp_take) begin
                snp_op_q   <= bus.snp_op;
                snp_line_q <= bus.snp_addr[ADDRESS_BITS-1:OFFSET_BITS];
            end
            proto_err_q <= proto_err_q
                         | (bus.l2_resp && state_q != WAIT_RESP)
                         | (bus.dsnp_done && state_q != SNOOP)
                         | (start_txn && pick_d && bus.d_op == 2'd3);
        end
    end

    always_comb begin
        bus.l2_valid   = (state_q == ISSUE);
        bus.l2_op      = (state_q == ISSUE) ? txn_q.op : 2'd0;
        bus.l2_addr    = (state_q == ISSUE) ? {txn_q.line, {OFFSET_BITS{1'b0}}} : '0;
        bus.dsnp_valid = (state_q == SNOOP);
        bus.dsnp_op    = (state_q == SNOOP) ? snp_op_q : 1'b0;
        bus.dsnp_addr  = (state_q == SNOOP) ? {snp_line_q, {OFFSET_BITS{1'b0}}} : '0;
        bus.i_gnt      = i_gnt_q;
        bus.d_gnt      = d_gnt_q;
        bus.i_done     = i_done_q;
        bus.d_done     = d_done_q;
        bus.snp_ready  = snp_ready_q;
        bus.proto_err  = proto_err_q;
    end
endmodule

// File: tb/tb_l1_l2_bus_arbiter.sv
// Directed bench for l1_l2_bus_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_l1_l2_bus_arbiter;
    localparam logic [6:0] G_I = 7'b1000000;
    localparam logic [6:0] D_I = 7'b0100000;
    localparam logic [6:0] G_D = 7'b0010000;
    localparam logic [6:0] D_D = 7'b0001000;
    localparam logic [6:0] L2V = 7'b0000100;
    localparam logic [6:0] SR  = 7'b0000010;
    localparam logic [6:0] DSV = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    l1_l2_bus_arbiter_if #(.ADDRESS_BITS(32)) bus ();

    l1_l2_bus_arbiter #(.ADDRESS_BITS(32), .OFFSET_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {i_gnt, i_done, d_gnt, d_done, l2_valid, snp_ready, dsnp_valid}
    task automatic ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, bus.i_gnt, bus.i_done, bus.d_gnt, bus.d_done,
                  bus.l2_valid, bus.snp_ready, bus.dsnp_valid}, {25'd0, exp});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc();
        ctl("reset_ctl", 7'd0);
        chk("reset_proto_err", {31'd0, bus.proto_err}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_op = 0; bus.d_addr = 0;
        bus.l2_ready = 0; bus.l2_resp = 0; bus.snp_valid = 0; bus.snp_op = 0;
        bus.snp_addr = 0; bus.dsnp_done = 0;

        // Reset state
        cyc();
        ctl("rst_ctl", 7'd0);
        chk("rst_proto_err", {31'd0, bus.proto_err}, 32'd0);
        chk("rst_l2_addr", bus.l2_addr, 32'd0);
        rst = 1'b0;

        // Single I miss
        bus.i_req = 1; bus.i_addr = 32'h0000_1234; bus.l2_ready = 1;
        cyc();
        ctl("t1_grant", G_I | L2V);
        chk("t1_l2_op", {30'd0, bus.l2_op}, 32'd0);
        chk("t1_l2_addr", bus.l2_addr, 32'h0000_1200);
        bus.i_req = 0;
        cyc(); ctl("t1_wait_a", 7'd0);
        cyc(); ctl("t1_wait_b", 7'd0);
        bus.l2_resp = 1;
        cyc(); ctl("t1_done", D_I);
        bus.l2_resp = 0;
        cyc(); ctl("t1_done_once", 7'd0);

        // Round-robin from reset: I, D, I, D
        pulse_reset();
        bus.i_req = 1; bus.i_addr = 32'h1000_0080;
        bus.d_req = 1; bus.d_op = 2'd0; bus.d_addr = 32'h2000_0047;
        for (int k = 0; k < 4; k++) begin
            bit own_d;
            own_d = (k % 2 == 1);
            cyc();
            ctl("t2_grant", own_d ? (G_D | L2V) : (G_I | L2V));
            chk("t2_l2_addr", bus.l2_addr, own_d ? 32'h2000_0040 : 32'h1000_0080);
            cyc();
            ctl("t2_wait", 7'd0);
            bus.l2_resp = 1;
            cyc();
            ctl("t2_done", own_d ? D_D : D_I);
            bus.l2_resp = 0;
            if (k == 3) begin
                bus.i_req = 0; bus.d_req = 0;
            end
        end
        cyc(); ctl("t2_quiet", 7'd0);

        // Writeback beats a pending I request; snoop arrives during WAIT_RESP
        bus.i_req = 1; bus.d_req = 1; bus.d_op = 2'd2; bus.d_addr = 32'hABCD_EF40;
        cyc();
        ctl("t3_wb_grant", G_D | L2V);
        chk("t3_l2_op", {30'd0, bus.l2_op}, 32'd2);
        chk("t3_l2_addr", bus.l2_addr, 32'hABCD_EF40);
        bus.d_req = 0;
        cyc(); ctl("t3_wait", 7'd0);
        bus.snp_valid = 1; bus.snp_op = 1'b0; bus.snp_addr = 32'h8000_0080;
        cyc(); ctl("t4_snoop_deferred", 7'd0);
        bus.l2_resp = 1;
        cyc(); ctl("t4_wb_done", D_D);
        bus.l2_resp = 0;
        cyc();
        ctl("t4_snoop_a", DSV);
        chk("t4_dsnp_addr", bus.dsnp_addr, 32'h8000_0080);
        chk("t4_dsnp_op", {31'd0, bus.dsnp_op}, 32'd0);
        cyc(); ctl("t4_snoop_b", DSV);
        bus.dsnp_done = 1;
        cyc(); ctl("t4_snp_ready", SR);
        bus.dsnp_done = 0; bus.snp_valid = 0;
        cyc();
        ctl("t4_i_after_snoop", G_I | L2V);
        chk("t4_i_l2_addr", bus.l2_addr, 32'h1000_0080);
        bus.i_req = 0;
        cyc(); ctl("t4_i_wait", 7'd0);
        bus.l2_resp = 1;
        cyc();
        ctl("t4_i_done", D_I);
        chk("t4_no_err", {31'd0, bus.proto_err}, 32'd0);
        bus.l2_resp = 0;

        // Stray l2_resp in IDLE
        cyc(); ctl("t5_idle", 7'd0);
        bus.l2_resp = 1;
        cyc();
        ctl("t5_resp_ignored", 7'd0);
        chk("t5_proto_err", {31'd0, bus.proto_err}, 32'd1);
        bus.l2_resp = 0;
        cyc(); cyc();
        chk("t5_proto_err_sticky", {31'd0, bus.proto_err}, 32'd1);

        // Illegal d_op issued as READ, with L2 stall
        pulse_reset();
        bus.d_req = 1; bus.d_op = 2'd3; bus.d_addr = 32'h5555_557F; bus.l2_ready = 0;
        cyc();
        ctl("t6_grant", G_D | L2V);
        chk("t6_l2_op", {30'd0, bus.l2_op}, 32'd0);
        chk("t6_l2_addr", bus.l2_addr, 32'h5555_5540);
        chk("t6_proto_err", {31'd0, bus.proto_err}, 32'd1);
        bus.d_req = 0;
        cyc();
        ctl("t6_stall", L2V);
        chk("t6_addr_stable", bus.l2_addr, 32'h5555_5540);
        bus.l2_ready = 1;
        cyc(); ctl("t6_wait", 7'd0);

        // Async reset in WAIT_RESP with l2_resp and both requests pending
        bus.i_req = 1; bus.i_addr = 32'h0000_3FC0; bus.d_req = 1; bus.d_op = 2'd0;
        bus.l2_resp = 1;
        rst = 1'b1;
        #1;
        ctl("t7_async_ctl", 7'd0);
        chk("t7_async_proto_err", {31'd0, bus.proto_err}, 32'd0);
        chk("t7_async_l2_addr", bus.l2_addr, 32'd0);
        cyc();
        ctl("t7_no_done", 7'd0);
        rst = 1'b0; bus.l2_resp = 0;
        cyc();
        ctl("t7_i_first", G_I | L2V);
        chk("t7_l2_addr", bus.l2_addr, 32'h0000_3FC0);
        bus.i_req = 0; bus.d_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
